// File: rtl/cpu_controller_if.sv
// Harness/datapath-facing bundle of the lab CPU controller.
// The slave modport is the controller's view. The master modport is the view of the
// harness and datapath that surround it.
interface cpu_controller_if #(
  parameter int DW = 16
);
  logic [15:0]   in;
  logic          load;
  logic          s;
  logic          w;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic [3:0]    vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic [DW-1:0] sximm8;
  logic [DW-1:0] sximm5;

  modport master (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller.sv
// Lab CPU control unit. It holds the instruction register, decodes the instruction and
// runs a Moore FSM that drives the datapath control strobes.
// Supported instructions: MOV imm, MOV reg, ADD, CMP, AND and MVN.
// Optional feature: when CTRL_ILLEGAL_TRAP_EN is defined, an undecodable instruction
// parks the FSM in HALT, with the 'illegal' output high, until reset.
// The DW parameter must match the DW of the connected cpu_controller_if.
module cpu_controller #(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.slave   bus
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_OPER      = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT      = 3'd7;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign rm     = ir_q[2:0];

  // Next state and IR capture. The IR loads only in WAIT, so a load that arrives
  // together with s is the instruction that DECODE sees.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.load) ir_d = bus.in;
        if (bus.s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        case ({opcode, op})
          5'b110_10:                       state_d = S_WRITE_IMM;
          5'b110_00, 5'b101_11:            state_d = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                         state_d = S_HALT;
`else
          default:                         state_d = S_WAIT;
`endif
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_OPER;
      S_OPER:      state_d = ({opcode, op} == 5'b101_01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:      state_d = S_HALT;
`endif
      default:     state_d = S_WAIT;
    endcase
  end

  // State and instruction register, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore control outputs, decoded from the state and the IR only.
  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = rn;
    bus.writenum = rn;
    bus.write    = 1'b0;
    bus.vsel     = 4'b0001;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    case (state_q)
      S_WAIT:      bus.w = 1'b1;
      S_WRITE_IMM: begin
        bus.vsel  = 4'b0100;
        bus.write = 1'b1;
      end
      S_GET_A:     bus.loada = 1'b1;
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      S_OPER: begin
        bus.asel = (opcode == 3'b110);
        if ({opcode, op} == 5'b101_01) bus.loads = 1'b1;
        else                           bus.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.shift  = ir_q[4:3];
  assign bus.ALUop  = ir_q[12:11];
  assign bus.sximm8 = DW'($signed(ir_q[7:0]));
  assign bus.sximm5 = DW'($signed(ir_q[4:0]));

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_HALT);
`endif

endmodule
